// File: rtl/conv_fft_mem_sched.sv
// Write/read address scheduler for the FFT convolution memories: stores image and two kernel banks, then sweeps all pairs.
// Optional macro CONV_FFT_SCHED_OVF_CHECK_EN enables the sticky err flag for fft_valid outside the write phases.
module conv_fft_mem_sched #(
    parameter int IMG_AW = 13,
    parameter int KER_AW = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IMG_AW-1:0] num_img,
    input  logic [KER_AW-1:0] num_ker,
    input  logic              fft_valid,
    output logic              image_we,
    output logic [IMG_AW-1:0] image_waddr,
    output logic [1:0]        kernel_we,
    output logic [KER_AW-1:0] kernel_waddr,
    output logic [IMG_AW-1:0] image_raddr,
    output logic [KER_AW-1:0] kernel_raddr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);
    typedef enum logic [2:0] {IDLE, WR_IMG, WR_K0, WR_K1, RD, FIN} state_t;

    localparam logic [IMG_AW-1:0] IMG_ONE = {{(IMG_AW-1){1'b0}}, 1'b1};
    localparam logic [KER_AW-1:0] KER_ONE = {{(KER_AW-1){1'b0}}, 1'b1};

    state_t            state;
    logic [IMG_AW-1:0] n_img;
    logic [IMG_AW-1:0] img_cnt;
    logic [KER_AW-1:0] n_ker;
    logic [KER_AW-1:0] ker_cnt;
    logic              img_last_wr;
    logic              ker_last_wr;
    logic              last_pair;

    assign img_last_wr = (img_cnt + IMG_ONE) == n_img;
    assign ker_last_wr = (ker_cnt + KER_ONE) == n_ker;
    assign last_pair   = (image_raddr == n_img - IMG_ONE) && (kernel_raddr == n_ker - KER_ONE);
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    // Handshake: rd_valid rises one cycle after a pair's addresses are presented (1-cycle memory
    // latency); while rd_valid && !rd_ready addresses and rd_valid hold, and a pair is consumed
    // only on rd_valid && rd_ready, after which the next pair is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            n_img        <= '0;
            n_ker        <= '0;
            img_cnt      <= '0;
            ker_cnt      <= '0;
            image_we     <= 1'b0;
            image_waddr  <= '0;
            kernel_we    <= 2'b00;
            kernel_waddr <= '0;
            image_raddr  <= '0;
            kernel_raddr <= '0;
            rd_valid     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            image_we  <= 1'b0;
            kernel_we <= 2'b00;
            done      <= 1'b0;
`ifdef CONV_FFT_SCHED_OVF_CHECK_EN
            if (fft_valid && (state == IDLE || state == RD || state == FIN))
                err <= 1'b1;
`else
            err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        n_img <= num_img;
                        n_ker <= num_ker;
                        if (num_img != '0)
                            state <= WR_IMG;
                        else if (num_ker != '0)
                            state <= WR_K0;
                        else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                WR_IMG: begin
                    if (fft_valid) begin
                        image_we    <= 1'b1;
                        image_waddr <= img_cnt;
                        if (img_last_wr) begin
                            img_cnt <= '0;
                            // With no kernels there are no pairs to read.
                            if (n_ker != '0)
                                state <= WR_K0;
                            else begin
                                state <= FIN;
                                done  <= 1'b1;
                            end
                        end else begin
                            img_cnt <= img_cnt + IMG_ONE;
                        end
                    end
                end
                WR_K0: begin
                    if (fft_valid) begin
                        kernel_we    <= 2'b01;
                        kernel_waddr <= ker_cnt;
                        if (ker_last_wr) begin
                            ker_cnt <= '0;
                            state   <= WR_K1;
                        end else begin
                            ker_cnt <= ker_cnt + KER_ONE;
                        end
                    end
                end
                WR_K1: begin
                    if (fft_valid) begin
                        kernel_we    <= 2'b10;
                        kernel_waddr <= ker_cnt;
                        if (ker_last_wr) begin
                            ker_cnt <= '0;
                            if (n_img != '0)
                                state <= RD;
                            else begin
                                state <= FIN;
                                done  <= 1'b1;
                            end
                        end else begin
                            ker_cnt <= ker_cnt + KER_ONE;
                        end
                    end
                end
                RD: begin
                    if (!rd_valid) begin
                        rd_valid <= 1'b1;
                    end else if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (last_pair) begin
                            state        <= FIN;
                            done         <= 1'b1;
                            image_raddr  <= '0;
                            kernel_raddr <= '0;
                        end else if (kernel_raddr == n_ker - KER_ONE) begin
                            kernel_raddr <= '0;
                            image_raddr  <= image_raddr + IMG_ONE;
                        end else begin
                            kernel_raddr <= kernel_raddr + KER_ONE;
                        end
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_fft_mem_sched.sv
// Self-checking bench for conv_fft_mem_sched: randomized passes scored against an
// expected write/read sequence built from the counts; honours CONV_FFT_SCHED_OVF_CHECK_EN.
module tb_conv_fft_mem_sched;
    localparam int IMG_AW = 13;
    localparam int KER_AW = 9;

    logic              clk;
    logic              reset;
    logic              start;
    logic [IMG_AW-1:0] num_img;
    logic [KER_AW-1:0] num_ker;
    logic              fft_valid;
    logic              image_we;
    logic [IMG_AW-1:0] image_waddr;
    logic [1:0]        kernel_we;
    logic [KER_AW-1:0] kernel_waddr;
    logic [IMG_AW-1:0] image_raddr;
    logic [KER_AW-1:0] kernel_raddr;
    logic              rd_valid;
    logic              rd_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        dbg_state;

    conv_fft_mem_sched #(.IMG_AW(IMG_AW), .KER_AW(KER_AW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_img(num_img), .num_ker(num_ker),
        .fft_valid(fft_valid), .image_we(image_we), .image_waddr(image_waddr),
        .kernel_we(kernel_we), .kernel_waddr(kernel_waddr), .image_raddr(image_raddr),
        .kernel_raddr(kernel_raddr), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cyc = 0;
    logic exp_err;
    logic [31:0] exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] obs;
    logic [31:0] prev_rd;
    logic prev_stall = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write events: kind 0 = image, 1 = kernel bank 0, 2 = kernel bank 1, 3 = illegal strobe mix.
    function automatic logic [31:0] wr_code(input int kind, input int addr);
        return 32'(kind * 8192 + addr);
    endfunction

    function automatic logic [31:0] rd_code(input int img, input int ker);
        return 32'(img * 512 + ker);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (image_we || kernel_we != 2'b00) begin
                if (image_we && kernel_we == 2'b00) obs = wr_code(0, int'(image_waddr));
                else if (!image_we && kernel_we == 2'b01) obs = wr_code(1, int'(kernel_waddr));
                else if (!image_we && kernel_we == 2'b10) obs = wr_code(2, int'(kernel_waddr));
                else obs = wr_code(3, 0);
                if (exp_wr_q.size() == 0) check("wr_extra", obs, 32'hffff_ffff);
                else check("wr", obs, exp_wr_q.pop_front());
            end
            if (prev_stall) begin
                check("rd_hold_v", 32'(rd_valid), 1);
                check("rd_hold_a", rd_code(int'(image_raddr), int'(kernel_raddr)), prev_rd);
            end
            if (rd_valid && rd_ready) begin
                obs = rd_code(int'(image_raddr), int'(kernel_raddr));
                acc_cyc = cyc;
                if (exp_rd_q.size() == 0) check("rd_extra", obs, 32'hffff_ffff);
                else check("rd", obs, exp_rd_q.pop_front());
            end
            prev_stall = rd_valid && !rd_ready;
            prev_rd = rd_code(int'(image_raddr), int'(kernel_raddr));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // mode: 0 = always ready, 1 = random ready, 2 = hold ready low 4 cycles at pair (1,0)
    task automatic run_pass(input int ni, input int nk, input int mode, input bit ovf, input int restart_at);
        int d0;
        int stall_left;
        int stalls;
        int gap;
        d0 = done_cnt;
        stall_left = 4;
        stalls = 0;
        for (int i = 0; i < ni; i++) exp_wr_q.push_back(wr_code(0, i));
        for (int b = 1; b <= 2; b++)
            for (int k = 0; k < nk; k++) exp_wr_q.push_back(wr_code(b, k));
        for (int i = 0; i < ni; i++)
            for (int k = 0; k < nk; k++) exp_rd_q.push_back(rd_code(i, k));
        num_img = IMG_AW'(ni);
        num_ker = KER_AW'(nk);
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_start", 32'(busy), 1);
        for (int p = 0; p < ni + 2 * nk; p++) begin
            if (p == restart_at) begin
                num_img = IMG_AW'(ni + 4);
                num_ker = KER_AW'(nk + 3);
                start = 1'b1;
                step();
                start = 1'b0;
            end
            fft_valid = 1'b1;
            step();
            fft_valid = 1'b0;
            gap = $urandom_range(0, 2);
            repeat (gap) step();
        end
        for (int it = 0; it < 2000 && done_cnt == d0 && !done; it++) begin
            case (mode)
                0: rd_ready = 1'b1;
                1: rd_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (rd_valid && image_raddr == 1 && kernel_raddr == 0 && stall_left > 0) begin
                        rd_ready = 1'b0;
                        stall_left--;
                        stalls++;
                    end else begin
                        rd_ready = 1'b1;
                    end
                end
            endcase
            fft_valid = ovf && it == 1;
            step();
        end
        fft_valid = 1'b0;
        rd_ready = 1'b1;
        repeat (3) step();
        check("done_cnt", 32'(done_cnt - d0), 1);
        check("wr_left", 32'(exp_wr_q.size()), 0);
        check("rd_left", 32'(exp_rd_q.size()), 0);
        check("busy_end", 32'(busy), 0);
        if (mode == 0 && ni * nk > 0) check("done_lat", 32'(done_cyc), 32'(acc_cyc + 1));
        if (mode == 2) check("stall_cycles", 32'(stalls), 4);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, {29'b0, image_we, kernel_we}, 0);
        check({tag, "_waddr"}, {10'b0, image_waddr, kernel_waddr}, 0);
        check({tag, "_raddr"}, {10'b0, image_raddr, kernel_raddr}, 0);
        check({tag, "_flags"}, {28'b0, rd_valid, busy, done, err}, 0);
    endtask

    initial begin
`ifdef CONV_FFT_SCHED_OVF_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        reset = 1'b1;
        start = 1'b0;
        num_img = '0;
        num_ker = '0;
        fft_valid = 1'b0;
        rd_ready = 1'b1;
        repeat (3) step();
        check_reset_outputs("rst");
        reset = 1'b0;
        step();
        check_reset_outputs("idle");

        run_pass(3, 2, 0, 1'b0, -1);
        run_pass(3, 2, 2, 1'b0, -1);
        run_pass(0, 1, 0, 1'b0, -1);
        run_pass(0, 0, 0, 1'b0, -1);
        run_pass(2, 0, 1, 1'b0, -1);
        run_pass(3, 2, 1, 1'b0, 1);

        // Abort in the kernel bank 0 phase: two image writes and one kernel write land first.
        for (int i = 0; i < 2; i++) exp_wr_q.push_back(wr_code(0, i));
        exp_wr_q.push_back(wr_code(1, 0));
        begin
            int d0;
            d0 = done_cnt;
            num_img = IMG_AW'(2);
            num_ker = KER_AW'(3);
            start = 1'b1;
            step();
            start = 1'b0;
            repeat (3) begin
                fft_valid = 1'b1;
                step();
                fft_valid = 1'b0;
            end
            step();
            check("mid_wr_left", 32'(exp_wr_q.size()), 0);
            check("mid_busy", 32'(busy), 1);
            reset = 1'b1;
            step();
            check_reset_outputs("mid_rst");
            reset = 1'b0;
            repeat (3) begin
                fft_valid = 1'b1;
                step();
                fft_valid = 1'b0;
            end
            repeat (4) step();
            check("mid_done", 32'(done_cnt - d0), 0);
            check("mid_idle", 32'(busy), 0);
        end

        // fft_valid during RD: dropped, err set only when the check is built in.
        run_pass(2, 2, 0, 1'b1, -1);
        check("err_rd", 32'(err), 32'(exp_err));
        run_pass(1, 1, 0, 1'b0, -1);
        check("err_sticky", 32'(err), 32'(exp_err));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("err_clr", 32'(err), 0);
        fft_valid = 1'b1;
        step();
        fft_valid = 1'b0;
        step();
        check("err_idle", 32'(err), 32'(exp_err));
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        for (int r = 0; r < 5; r++)
            run_pass($urandom_range(0, 4), $urandom_range(0, 3), 1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
